text_overlay_gen: RTL and testbench

Parametrised, pipelined text overlay for the Pong VGA path. Renders three text regions from the ASCII glyph ROM: the score/ball status line, the "PONG" logo and a blinking "GAME OVER" banner. Each region has its own glyph scale and colour, and regions can be enabled per game state. The score line highlights on any score change. The block sits between the VGA sync counter (`x`, `y`, `frame_tick`) and the final RGB mux. It replaces the fixed-size combinational text generator with a registered design whose latency is fixed and documented.

---
 rtl/text_overlay_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_text_overlay_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_overlay_gen.sv
`default_nettype none
// ============================================================================
// Module   : text_overlay_gen
// Purpose  : Pipelined text overlay for the Pong VGA path. Renders the
//            score/ball status line, the "PONG" logo and a blinking
//            "GAME OVER" banner from a built-in glyph ROM. Each region has its
//            own power-of-two glyph scale and colour. Fixed 3-clock latency
//            from (x, y, enables, digits) to (text_on, text_rgb).
// Ports    : clk        - pixel clock
//            reset      - asynchronous, active-high reset
//            x, y       - current pixel coordinate (10 bits each)
//            frame_tick - one-cycle pulse per frame (blink / highlight timing)
//            dig3..dig0 - score digits {P1 tens, P1 units, P2 tens, P2 units}
//            ball       - remaining balls
//            show_logo  - logo region enable
//            show_over  - banner region enable (rising edge restarts blink)
//            text_on    - registered {score, logo, over} lit-pixel flags
//            text_rgb   - registered 12-bit colour, 0 when text_on == 0
// Revision : 1.0 - initial release
// ============================================================================
module text_overlay_gen #(
    parameter int          SCORE_SCALE   = 2,
    parameter int          LOGO_SCALE    = 8,
    parameter int          OVER_SCALE    = 4,
    parameter int          SCORE_Y       = 32,
    parameter int          LOGO_Y        = 256,
    parameter int          OVER_Y        = 192,
    parameter int          LOGO_X        = 192,
    parameter int          OVER_X        = 160,
    parameter logic [11:0] FG_COLOR      = 12'hFFF,
    parameter logic [11:0] OVER_COLOR    = 12'hF00,
    parameter logic [11:0] HILITE_COLOR  = 12'hFF0,
    parameter int          BLINK_FRAMES  = 30,
    parameter int          HILITE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic [3:0]  dig3,
    input  logic [3:0]  dig2,
    input  logic [3:0]  dig1,
    input  logic [3:0]  dig0,
    input  logic [4:0]  ball,
    input  logic        show_logo,
    input  logic        show_over,
    output logic [2:0]  text_on,
    output logic [11:0] text_rgb
);

    // Scales are powers of two, so divisions become constant shifts.
    localparam int c_ss = $clog2(SCORE_SCALE);
    localparam int c_ls = $clog2(LOGO_SCALE);
    localparam int c_os = $clog2(OVER_SCALE);

    localparam int c_bw = $clog2(BLINK_FRAMES + 1);
    localparam int c_hw = $clog2(HILITE_FRAMES + 1);

    // Region bounds, half-open [lo, hi), in 11 bits to avoid overflow.
    localparam logic [10:0] c_score_y0 = 11'(SCORE_Y);
    localparam logic [10:0] c_score_y1 = 11'(SCORE_Y + 16 * SCORE_SCALE);
    localparam logic [10:0] c_score_x1 = 11'(20 * 8 * SCORE_SCALE);
    localparam logic [10:0] c_logo_y0  = 11'(LOGO_Y);
    localparam logic [10:0] c_logo_y1  = 11'(LOGO_Y + 16 * LOGO_SCALE);
    localparam logic [10:0] c_logo_x0  = 11'(LOGO_X);
    localparam logic [10:0] c_logo_x1  = 11'(LOGO_X + 4 * 8 * LOGO_SCALE);
    localparam logic [10:0] c_over_y0  = 11'(OVER_Y);
    localparam logic [10:0] c_over_y1  = 11'(OVER_Y + 16 * OVER_SCALE);
    localparam logic [10:0] c_over_x0  = 11'(OVER_X);
    localparam logic [10:0] c_over_x1  = 11'(OVER_X + 9 * 8 * OVER_SCALE);

    // ------------------------------------------------------------------------
    // Glyph ROM contents. Each glyph is a 5x7 pattern, rows top to bottom,
    // MSB of each 5-bit row is the leftmost pixel. In the 8x16 cell the
    // pattern sits at pixel columns 1..5 and each pattern row covers two
    // cell rows starting at cell row 2. Unlisted codes are blank.
    // ------------------------------------------------------------------------
    function automatic logic [34:0] font5x7(input logic [6:0] code);
        case (code)
            7'h30: font5x7 = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            7'h31: font5x7 = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            7'h32: font5x7 = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            7'h33: font5x7 = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            7'h34: font5x7 = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            7'h35: font5x7 = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            7'h36: font5x7 = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            7'h37: font5x7 = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            7'h38: font5x7 = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            7'h39: font5x7 = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            7'h2D: font5x7 = {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
            7'h3A: font5x7 = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
            7'h53: font5x7 = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
            7'h42: font5x7 = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
            7'h41: font5x7 = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            7'h4C: font5x7 = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
            7'h50: font5x7 = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
            7'h4F: font5x7 = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            7'h4E: font5x7 = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
            7'h47: font5x7 = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
            7'h4D: font5x7 = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
            7'h45: font5x7 = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
            7'h56: font5x7 = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            7'h52: font5x7 = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
            default: font5x7 = 35'h0;
        endcase
    endfunction

    // One 8-bit ROM word: bit 7 is the leftmost pixel of the cell row.
    function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
        logic [34:0] pat;
        logic [2:0]  prow;
        logic [4:0]  five;
        pat  = font5x7(code);
        prow = 3'((row - 4'd2) >> 1);
        case (prow)
            3'd0:    five = pat[34:30];
            3'd1:    five = pat[29:25];
            3'd2:    five = pat[24:20];
            3'd3:    five = pat[19:15];
            3'd4:    five = pat[14:10];
            3'd5:    five = pat[9:5];
            3'd6:    five = pat[4:0];
            default: five = 5'h00;
        endcase
        if (row < 4'd2) begin
            glyph_row = 8'h00;
        end else begin
            glyph_row = {1'b0, five, 2'b00};
        end
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] v);
        digit_code = (v <= 4'd9) ? (7'h30 + {3'b000, v}) : 7'h2D;
    endfunction

    function automatic logic [6:0] score_code(input logic [4:0] col, input logic [3:0] d3,
                                              input logic [3:0] d2, input logic [3:0] d1,
                                              input logic [3:0] d0, input logic [4:0] b);
        case (col)
            5'd0:    score_code = 7'h53;
            5'd1:    score_code = 7'h31;
            5'd2:    score_code = 7'h3A;
            5'd3:    score_code = digit_code(d3);
            5'd4:    score_code = digit_code(d2);
            5'd7:    score_code = 7'h42;
            5'd8:    score_code = 7'h41;
            5'd9:    score_code = 7'h4C;
            5'd10:   score_code = 7'h4C;
            5'd11:   score_code = 7'h3A;
            5'd12:   score_code = (b <= 5'd9) ? (7'h30 + {2'b00, b}) : 7'h39;
            5'd15:   score_code = 7'h53;
            5'd16:   score_code = 7'h32;
            5'd17:   score_code = 7'h3A;
            5'd18:   score_code = digit_code(d1);
            5'd19:   score_code = digit_code(d0);
            default: score_code = 7'h20;
        endcase
    endfunction

    function automatic logic [6:0] logo_code(input logic [1:0] col);
        case (col)
            2'd0:    logo_code = 7'h50;
            2'd1:    logo_code = 7'h4F;
            2'd2:    logo_code = 7'h4E;
            default: logo_code = 7'h47;
        endcase
    endfunction

    function automatic logic [6:0] over_code(input logic [3:0] col);
        case (col)
            4'd0:    over_code = 7'h47;
            4'd1:    over_code = 7'h41;
            4'd2:    over_code = 7'h4D;
            4'd3:    over_code = 7'h45;
            4'd5:    over_code = 7'h4F;
            4'd6:    over_code = 7'h56;
            4'd7:    over_code = 7'h45;
            4'd8:    over_code = 7'h52;
            default: over_code = 7'h20;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Frame-rate state: banner blink and score highlight
    // ------------------------------------------------------------------------
    logic [c_bw-1:0] r_blink_cnt;
    logic            r_blink_phase;
    logic            r_over_q;
    logic [c_hw-1:0] r_hilite;
    logic [15:0]     r_prev_score;
    logic            w_over_rise;
    logic            w_phase_eff;
    logic [15:0]     w_score;

    assign w_over_rise = show_over & ~r_over_q;
    // The restart edge forces the banner visible in the very cycle it is
    // enabled, not one cycle later when the phase register catches up.
    assign w_phase_eff = r_blink_phase | w_over_rise;
    assign w_score     = {dig3, dig2, dig1, dig0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_over_q      <= 1'b0;
        end else begin
            r_over_q <= show_over;
            if (w_over_rise) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (frame_tick) begin
                if (r_blink_cnt == c_bw'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_bw'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hilite     <= '0;
            r_prev_score <= 16'h0000;
        end else if (frame_tick) begin
            r_prev_score <= w_score;
            if (w_score != r_prev_score) begin
                r_hilite <= c_hw'(HILITE_FRAMES);
            end else if (r_hilite != '0) begin
                r_hilite <= r_hilite - c_hw'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // S0: region decode, character code, glyph row and bit index
    // ------------------------------------------------------------------------
    logic [10:0] w_x, w_y;
    logic [10:0] w_sdy, w_ldx, w_ldy, w_odx, w_ody;
    logic        w_score_hit, w_logo_hit, w_over_hit;
    logic [2:0]  w_hit;
    logic [6:0]  w_code;
    logic [3:0]  w_row;
    logic [2:0]  w_bit;
    logic [11:0] w_color;
    logic        w_unused_bits;

    assign w_x   = {1'b0, x};
    assign w_y   = {1'b0, y};
    assign w_sdy = w_y - c_score_y0;
    assign w_ldx = w_x - c_logo_x0;
    assign w_ldy = w_y - c_logo_y0;
    assign w_odx = w_x - c_over_x0;
    assign w_ody = w_y - c_over_y0;

    // Only a few bits of each offset are needed after the shift.
    assign w_unused_bits = ^{w_sdy, w_ldx, w_ldy, w_odx, w_ody};

    assign w_score_hit = (w_y >= c_score_y0) && (w_y < c_score_y1) && (w_x < c_score_x1);
    assign w_logo_hit  = show_logo && (w_y >= c_logo_y0) && (w_y < c_logo_y1)
                         && (w_x >= c_logo_x0) && (w_x < c_logo_x1);
    assign w_over_hit  = show_over && w_phase_eff && (w_y >= c_over_y0) && (w_y < c_over_y1)
                         && (w_x >= c_over_x0) && (w_x < c_over_x1);

    // Priority is by region coverage, not by lit pixel: an unlit score pixel
    // masks whatever lies underneath it.
    always_comb begin
        w_hit   = 3'b000;
        w_code  = 7'h00;
        w_row   = 4'h0;
        w_bit   = 3'h0;
        w_color = 12'h000;
        if (w_score_hit) begin
            w_hit   = 3'b100;
            w_code  = score_code(w_x[3 + c_ss +: 5], dig3, dig2, dig1, dig0, ball);
            w_row   = w_sdy[c_ss +: 4];
            w_bit   = w_x[c_ss +: 3];
            w_color = (r_hilite != '0) ? HILITE_COLOR : FG_COLOR;
        end else if (w_logo_hit) begin
            w_hit   = 3'b010;
            w_code  = logo_code(w_ldx[3 + c_ls +: 2]);
            w_row   = w_ldy[c_ls +: 4];
            w_bit   = w_ldx[c_ls +: 3];
            w_color = FG_COLOR;
        end else if (w_over_hit) begin
            w_hit   = 3'b001;
            w_code  = over_code(w_odx[3 + c_os +: 4]);
            w_row   = w_ody[c_os +: 4];
            w_bit   = w_odx[c_os +: 3];
            w_color = OVER_COLOR;
        end
    end

    logic [2:0]  r_s0_hit, r_s1_hit;
    logic [6:0]  r_s0_code;
    logic [3:0]  r_s0_row;
    logic [2:0]  r_s0_bit, r_s1_bit;
    logic [11:0] r_s0_color, r_s1_color;
    logic [7:0]  r_s1_data;
    logic        w_lit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_hit   <= 3'b000;
            r_s0_code  <= 7'h00;
            r_s0_row   <= 4'h0;
            r_s0_bit   <= 3'h0;
            r_s0_color <= 12'h000;
        end else begin
            r_s0_hit   <= w_hit;
            r_s0_code  <= w_code;
            r_s0_row   <= w_row;
            r_s0_bit   <= w_bit;
            r_s0_color <= w_color;
        end
    end

    // S1: synchronous ROM read; sideband travels alongside the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_data  <= 8'h00;
            r_s1_hit   <= 3'b000;
            r_s1_bit   <= 3'h0;
            r_s1_color <= 12'h000;
        end else begin
            r_s1_data  <= glyph_row(r_s0_code, r_s0_row);
            r_s1_hit   <= r_s0_hit;
            r_s1_bit   <= r_s0_bit;
            r_s1_color <= r_s0_color;
        end
    end

    // S2: pick the pixel (bit index 0 is word bit 7) and register outputs.
    assign w_lit = r_s1_data[3'd7 - r_s1_bit];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            text_on  <= 3'b000;
            text_rgb <= 12'h000;
        end else begin
            text_on  <= w_lit ? r_s1_hit : 3'b000;
            text_rgb <= (w_lit && (r_s1_hit != 3'b000)) ? r_s1_color : 12'h000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_overlay_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_overlay_gen
// Purpose  : Self-checking bench for text_overlay_gen. A behavioural pixel
//            model (strings, integer arithmetic, 5x7 font table) predicts
//            every output cycle; directed probes pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_overlay_gen;

    localparam int          SS = 2, LS = 8, OS = 4;
    localparam int          SY = 32, LY = 40, OY = 128;
    localparam int          LX = 192, OX = 160;
    localparam logic [11:0] FG = 12'hFFF, OC = 12'hF00, HC = 12'hFF0;
    localparam int          BF = 2, HF = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0, y = '0;
    logic        frame_tick = 1'b0;
    logic [3:0]  dig3 = '0, dig2 = '0, dig1 = '0, dig0 = '0;
    logic [4:0]  ball = '0;
    logic        show_logo = 1'b0, show_over = 1'b0;
    logic [2:0]  text_on;
    logic [11:0] text_rgb;

    int checks = 0;
    int fails  = 0;

    text_overlay_gen #(
        .SCORE_SCALE(SS), .LOGO_SCALE(LS), .OVER_SCALE(OS),
        .SCORE_Y(SY), .LOGO_Y(LY), .OVER_Y(OY), .LOGO_X(LX), .OVER_X(OX),
        .FG_COLOR(FG), .OVER_COLOR(OC), .HILITE_COLOR(HC),
        .BLINK_FRAMES(BF), .HILITE_FRAMES(HF)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0), .ball(ball),
        .show_logo(show_logo), .show_over(show_over),
        .text_on(text_on), .text_rgb(text_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [34:0] font(input byte ch);
        case (ch)
            "0": return {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
            "1": return {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            "2": return {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
            "3": return {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
            "4": return {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            "5": return {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            "6": return {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            "7": return {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            "8": return {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            "9": return {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            "-": return {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
            ":": return {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
            "S": return {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
            "B": return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
            "A": return {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
            "L": return {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
            "P": return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
            "O": return {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            "N": return {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
            "G": return {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
            "M": return {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
            "E": return {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
            "V": return {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
            "R": return {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
            default: return 35'h0;
        endcase
    endfunction

    // Pixel (col 0..7 from the left, row 0..15) of a glyph cell.
    function automatic bit glyph_lit(input byte ch, input int row, input int col);
        logic [34:0] p;
        int r;
        if (row < 2 || col < 1 || col > 5) return 1'b0;
        p = font(ch);
        r = (row - 2) / 2;
        return p[34 - 5 * r - (col - 1)];
    endfunction

    function automatic logic [7:0] glyph_byte(input byte ch, input int row);
        logic [7:0] b;
        for (int c = 0; c < 8; c++) b[7 - c] = glyph_lit(ch, row, c);
        return b;
    endfunction

    function automatic byte dch(input logic [3:0] v);
        return (v <= 9) ? byte'(8'h30 + v) : byte'(8'h2D);
    endfunction

    function automatic byte score_char(input int col, input logic [3:0] d3, input logic [3:0] d2,
                                       input logic [3:0] d1, input logic [3:0] d0, input logic [4:0] b);
        string s;
        byte bc;
        bc = (b <= 9) ? byte'(8'h30 + b) : byte'(8'h39);
        s = $sformatf("S1:%c%c  BALL:%c  S2:%c%c", dch(d3), dch(d2), bc, dch(d1), dch(d0));
        return s[col];
    endfunction

    function automatic logic [14:0] model_pix(input int px, input int py, input bit ph, input bit hl);
        string t;
        byte   ch;
        if (py >= SY && py < SY + 16 * SS && px / (8 * SS) < 20) begin
            ch = score_char(px / (8 * SS), dig3, dig2, dig1, dig0, ball);
            if (glyph_lit(ch, (py - SY) / SS, (px / SS) % 8)) return {3'b100, hl ? HC : FG};
            return 15'h0;
        end
        if (show_logo && py >= LY && py < LY + 16 * LS && px >= LX && px < LX + 32 * LS) begin
            t  = "PONG";
            ch = t[(px - LX) / (8 * LS)];
            if (glyph_lit(ch, (py - LY) / LS, ((px - LX) / LS) % 8)) return {3'b010, FG};
            return 15'h0;
        end
        if (show_over && ph && py >= OY && py < OY + 16 * OS && px >= OX && px < OX + 72 * OS) begin
            t  = "GAME OVER";
            ch = t[(px - OX) / (8 * OS)];
            if (glyph_lit(ch, (py - OY) / OS, ((px - OX) / OS) % 8)) return {3'b001, OC};
        end
        return 15'h0;
    endfunction

    // Model state, pipeline of predicted outputs (3-clock latency).
    int          m_bcnt, m_hil;
    bit          m_phase, m_over_q, m_rise;
    logic [15:0] m_prev, m_cur;
    logic [14:0] p0, p1, pout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bcnt = 0; m_phase = 1'b1; m_over_q = 1'b0;
            m_hil = 0; m_prev = 16'h0;
            p0 = '0; p1 = '0; pout = '0;
        end else begin
            m_rise = show_over && !m_over_q;
            pout = p1;
            p1   = p0;
            p0   = model_pix(int'(x), int'(y), m_phase || m_rise, m_hil != 0);
            m_over_q = show_over;
            if (m_rise) begin
                m_bcnt = 0; m_phase = 1'b1;
            end else if (frame_tick) begin
                m_bcnt = m_bcnt + 1;
                if (m_bcnt == BF) begin m_bcnt = 0; m_phase = !m_phase; end
            end
            if (frame_tick) begin
                m_cur = {dig3, dig2, dig1, dig0};
                if (m_cur != m_prev) m_hil = HF;
                else if (m_hil > 0) m_hil = m_hil - 1;
                m_prev = m_cur;
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        check("pixel", {17'h0, text_on, text_rgb}, reset ? 32'h0 : {17'h0, pout});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk); #1 frame_tick = 1'b1;
        @(negedge clk); #1 frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic probe(input string name, input int px, input int py,
                         input logic [2:0] eon, input logic [11:0] ergb);
        @(negedge clk); #1 x = 10'(px); y = 10'(py);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(name, {17'h0, text_on, text_rgb}, {17'h0, eon, ergb});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {17'h0, text_on, text_rgb}, 32'h0);

        // Model pins.
        check("font_1_row4", 32'(glyph_byte("1", 4)), 32'h30);
        check("dash_code", 32'(score_char(19, 4'd1, 4'd7, 4'd0, 4'hC, 5'd3)), 32'h2D);
        check("ball_clip", 32'(score_char(12, 4'd1, 4'd7, 4'd0, 4'hC, 5'd15)), 32'h39);
        check("score_S", 32'(score_char(0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0)), 32'h53);

        @(negedge clk); #1 reset = 1'b0;
        dig3 = 4'd1; dig2 = 4'd7; dig1 = 4'd0; dig0 = 4'd0; ball = 5'd3;

        probe("score_lit", 52, 40, 3'b100, FG);
        probe("score_dark", 50, 40, 3'b000, 12'h000);
        probe("score_edge", 330, 40, 3'b000, 12'h000);
        // Full scan of the score band row; the model checks every pixel.
        for (int i = 0; i < 640; i++) begin
            @(negedge clk); #1 x = 10'(i); y = 10'd40;
        end
        dig0 = 4'hC; ball = 5'd15;
        for (int i = 0; i < 320; i++) begin
            @(negedge clk); #1 x = 10'(i); y = 10'd44;
        end
        dig0 = 4'd0; ball = 5'd3;

        show_logo = 1'b1;
        probe("overlap_score", 200, 40, 3'b100, FG);
        probe("overlap_mask", 232, 56, 3'b000, 12'h000);
        probe("logo_lit", 208, 64, 3'b010, FG);
        show_logo = 1'b0;

        // Highlight: first tick sees a score differing from the reset sample.
        tick();
        probe("hilite_on", 52, 40, 3'b100, HC);
        ticks(HF - 1);
        probe("hilite_last", 52, 40, 3'b100, HC);
        tick();
        probe("hilite_off", 52, 40, 3'b100, FG);
        dig1 = 4'd1; tick();
        probe("hilite_change", 52, 40, 3'b100, HC);
        ticks(29);
        dig1 = 4'd2; tick();
        ticks(HF - 1);
        probe("hilite_reload", 52, 40, 3'b100, HC);
        tick();
        probe("hilite_reload_end", 52, 40, 3'b100, FG);

        // Blink: visible, visible, hidden, hidden, visible, visible.
        show_over = 1'b1;
        probe("blink_f0", 168, 136, 3'b001, OC);
        tick(); probe("blink_f1", 168, 136, 3'b001, OC);
        tick(); probe("blink_f2", 168, 136, 3'b000, 12'h000);
        tick(); probe("blink_f3", 168, 136, 3'b000, 12'h000);
        tick(); probe("blink_f4", 168, 136, 3'b001, OC);
        tick(); probe("blink_f5", 168, 136, 3'b001, OC);
        tick(); tick();

        // Asynchronous reset mid-line with the banner hidden.
        @(negedge clk); #1 x = 10'd52; y = 10'd40;
        @(posedge clk); #2 reset = 1'b1;
        #1 check("async_reset", {17'h0, text_on, text_rgb}, 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        probe("post_reset_banner", 168, 136, 3'b001, OC);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 299));
            frame_tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                dig3 = 4'($urandom); dig2 = 4'($urandom);
                dig1 = 4'($urandom); dig0 = 4'($urandom);
                ball = 5'($urandom);
            end
            if ($urandom_range(0, 299) == 0) show_logo = ~show_logo;
            if ($urandom_range(0, 249) == 0) show_over = ~show_over;
            if ($urandom_range(0, 1499) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk); #1 reset = 1'b0;
            end
        end
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
